// File: rtl/team_10_gpio_pkg.sv
// rtl/team_10_gpio_pkg.sv - register map, decode enum and byte-lane helper for the Wishbone GPIO controller
package team_10_gpio_pkg;

    localparam logic [7:0] OFS_DATA_OUT   = 8'h00;
    localparam logic [7:0] OFS_OEB        = 8'h04;
    localparam logic [7:0] OFS_DATA_IN    = 8'h08;
    localparam logic [7:0] OFS_IRQ_EN     = 8'h0C;
    localparam logic [7:0] OFS_EDGE_SEL   = 8'h10;
    localparam logic [7:0] OFS_IRQ_STATUS = 8'h14;

    typedef enum logic [2:0] {
        REG_DATA_OUT,
        REG_OEB,
        REG_DATA_IN,
        REG_IRQ_EN,
        REG_EDGE_SEL,
        REG_IRQ_STATUS,
        REG_NONE
    } reg_sel_e;

    typedef enum logic {
        WB_IDLE,
        WB_ACK
    } wb_state_e;

    function automatic reg_sel_e decode_reg(input logic [7:0] ofs);
        case (ofs)
            OFS_DATA_OUT:   return REG_DATA_OUT;
            OFS_OEB:        return REG_OEB;
            OFS_DATA_IN:    return REG_DATA_IN;
            OFS_IRQ_EN:     return REG_IRQ_EN;
            OFS_EDGE_SEL:   return REG_EDGE_SEL;
            OFS_IRQ_STATUS: return REG_IRQ_STATUS;
            default:        return REG_NONE;
        endcase
    endfunction

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_word;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) r[8*k +: 8] = wdata[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/team_10_gpio_sync.sv
// rtl/team_10_gpio_sync.sv - pad input synchroniser, edge-detect delay flop and per-pin edge select
module team_10_gpio_sync
    import team_10_gpio_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] edge_sel,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] dly_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
            dly_q <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
            dly_q <= stage_q[STAGES-1];
        end
    end

    assign sync_q     = stage_q[STAGES-1];
    assign rise       = sync_q & ~dly_q;
    assign fall       = ~sync_q & dly_q;
    assign edge_pulse = (edge_sel & rise) | (~edge_sel & fall);

endmodule

// File: rtl/team_10_wb_gpio_ctrl.sv
// rtl/team_10_wb_gpio_ctrl.sv - Wishbone slave GPIO controller with synchronised inputs and edge interrupts
module team_10_wb_gpio_ctrl
    import team_10_gpio_pkg::*;
#(
    parameter int          NUM_GPIO    = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oeb,
    output logic                irq
);

    localparam int WARM_CYCLES = SYNC_STAGES + 1;

    wb_state_e state_q, state_d;
    reg_sel_e  reg_sel;
    logic      req_raw, accept, wr;

    logic [NUM_GPIO-1:0] data_out_q, oeb_q, irq_en_q, edge_sel_q, status_q;
    logic [NUM_GPIO-1:0] sync_q, edge_pulse, edge_hit, clr_mask;
    logic [31:0]         cur_word, new_word, clr_word, rd_word;
    logic [2:0]          warm_cnt;
    logic                warm_done;

    function automatic logic [31:0] widen(input logic [NUM_GPIO-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NUM_GPIO-1:0] = v;
        return r;
    endfunction

    team_10_gpio_sync #(
        .WIDTH  (NUM_GPIO),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .din        (gpio_in),
        .edge_sel   (edge_sel_q),
        .sync_q     (sync_q),
        .edge_pulse (edge_pulse)
    );

    assign req_raw = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign reg_sel = decode_reg(wbs_adr_i[7:0]);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= WB_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: if (req_raw) state_d = WB_ACK;
            WB_ACK:  state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    // A request is only taken while idle, which forces the low cycle after each ack.
    always_comb begin
        wbs_ack_o = (state_q == WB_ACK);
        accept    = (state_q == WB_IDLE) && req_raw;
        wr        = accept && wbs_we_i;
    end

    always_comb begin
        cur_word = '0;
        case (reg_sel)
            REG_DATA_OUT:   cur_word = widen(data_out_q);
            REG_OEB:        cur_word = widen(oeb_q);
            REG_DATA_IN:    cur_word = widen(sync_q);
            REG_IRQ_EN:     cur_word = widen(irq_en_q);
            REG_EDGE_SEL:   cur_word = widen(edge_sel_q);
            REG_IRQ_STATUS: cur_word = widen(status_q);
            default:        cur_word = '0;
        endcase
        rd_word  = cur_word;
        new_word = lane_merge(cur_word, wbs_dat_i, wbs_sel_i);
        clr_word = lane_merge(32'h0, wbs_dat_i, wbs_sel_i);
    end

    assign warm_done = (warm_cnt == 3'(WARM_CYCLES));
    assign edge_hit  = warm_done ? edge_pulse : '0;
    assign clr_mask  = (wr && reg_sel == REG_IRQ_STATUS) ? clr_word[NUM_GPIO-1:0] : '0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            data_out_q <= '0;
            oeb_q      <= '1;
            irq_en_q   <= '0;
            edge_sel_q <= '0;
            status_q   <= '0;
            warm_cnt   <= '0;
            wbs_dat_o  <= '0;
            gpio_out   <= '0;
            gpio_oeb   <= '1;
            irq        <= 1'b0;
        end else begin
            if (wr && reg_sel == REG_DATA_OUT) data_out_q <= new_word[NUM_GPIO-1:0];
            if (wr && reg_sel == REG_OEB)      oeb_q      <= new_word[NUM_GPIO-1:0];
            if (wr && reg_sel == REG_IRQ_EN)   irq_en_q   <= new_word[NUM_GPIO-1:0];
            if (wr && reg_sel == REG_EDGE_SEL) edge_sel_q <= new_word[NUM_GPIO-1:0];
            // A fresh edge overrides a same-cycle write-one-to-clear.
            status_q <= (status_q & ~clr_mask) | edge_hit;
            if (!warm_done) warm_cnt <= warm_cnt + 3'd1;
            wbs_dat_o <= accept ? rd_word : 32'h0;
            gpio_out  <= data_out_q;
            gpio_oeb  <= oeb_q;
            irq       <= |(status_q & irq_en_q);
        end
    end

endmodule

// File: tb/tb_team_10_wb_gpio_ctrl.sv
// tb/tb_team_10_wb_gpio_ctrl.sv - self-checking bench for the Wishbone GPIO controller
module tb_team_10_wb_gpio_ctrl;

    localparam int          N    = 32;
    localparam int          SS   = 2;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   adr, dat_i;
    logic          ack;
    logic [31:0]   dat_o;
    logic [N-1:0]  gpio_in, gpio_out, gpio_oeb;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_out, m_oeb, m_en, m_sel, m_status, m_in;

    team_10_wb_gpio_ctrl #(.NUM_GPIO(N), .BASE_ADDR(BASE), .SYNC_STAGES(SS)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_i),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oeb  (gpio_oeb),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d; sel = s;
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_ack adr=%h got=%b want=1", a, ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ack_low adr=%h got=%b want=0", a, ack);
        end
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output logic acked);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        acked = 1'b0;
        d = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                acked = 1'b1;
                d = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_out = '0; m_oeb = '1; m_en = '0; m_sel = '0; m_status = '0;
    endtask

    task automatic model_write(input logic [7:0] ofs, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) if (s[k]) m = m | (32'hFF << (8 * k));
        case (ofs)
            8'h00: m_out    = (m_out & ~m) | (d & m);
            8'h04: m_oeb    = (m_oeb & ~m) | (d & m);
            8'h0C: m_en     = (m_en  & ~m) | (d & m);
            8'h10: m_sel    = (m_sel & ~m) | (d & m);
            8'h14: m_status = m_status & ~(d & m);
            default: ;
        endcase
    endtask

    // Each pin is assumed to change at most once between calls.
    task automatic model_edges(input logic [31:0] new_in);
        m_status = m_status | (new_in & ~m_in & m_sel) | (~new_in & m_in & ~m_sel);
        m_in = new_in;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic a;
        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
        gpio_in = '1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (gpio_oeb !== 32'hFFFF_FFFF || gpio_out !== 32'h0 || irq !== 1'b0 || ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs oeb=%h out=%h irq=%b ack=%b want oeb=ffffffff out=0 irq=0 ack=0",
                     gpio_oeb, gpio_out, irq, ack);
        end
        rst = 1'b0;
        model_reset();
        m_in = '1;
        repeat (10) @(negedge clk);
        wb_read(BASE + 32'h14, d, a);
        n_checks++;
        if (!a || d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_irq_status got=%h ack=%b want=0", d, a);
        end
        wb_read(BASE + 32'h08, d, a);
        n_checks++;
        if (!a || d !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL reset_data_in got=%h ack=%b want=ffffffff", d, a);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        logic a;
        wb_write(BASE + 32'h00, 32'hA5A5_1234, 4'b0101);
        model_write(8'h00, 32'hA5A5_1234, 4'b0101);
        wb_read(BASE + 32'h00, d, a);
        n_checks++;
        if (!a || d !== 32'h00A5_0034) begin
            n_fail++;
            $display("FAIL byte_lanes got=%h want=00a50034", d);
        end
        n_checks++;
        if (gpio_out !== m_out) begin
            n_fail++;
            $display("FAIL byte_lanes_pad got=%h want=%h", gpio_out, m_out);
        end
    endtask

    task automatic test_edge_irq();
        logic [31:0] d;
        logic a;
        wb_write(BASE + 32'h04, 32'h0, 4'hF);  model_write(8'h04, 32'h0, 4'hF);
        wb_write(BASE + 32'h10, 32'h8, 4'hF);  model_write(8'h10, 32'h8, 4'hF);
        wb_write(BASE + 32'h0C, 32'h8, 4'hF);  model_write(8'h0C, 32'h8, 4'hF);
        n_checks++;
        if (gpio_oeb !== 32'h0) begin
            n_fail++;
            $display("FAIL oeb_pad got=%h want=0", gpio_oeb);
        end
        @(negedge clk); gpio_in[3] = 1'b0;
        repeat (SS + 3) @(negedge clk);
        model_edges(gpio_in);
        @(negedge clk); gpio_in[3] = 1'b1;
        repeat (SS + 1) @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_early got=%b want=0", irq);
        end
        @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_rise got=%b want=1", irq);
        end
        model_edges(gpio_in);
        wb_read(BASE + 32'h14, d, a);
        n_checks++;
        if (!a || d !== m_status) begin
            n_fail++;
            $display("FAIL edge_status got=%h want=%h", d, m_status);
        end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        logic a;
        @(negedge clk); gpio_in[3] = 1'b0;
        repeat (SS + 3) @(negedge clk);
        model_edges(gpio_in);
        @(negedge clk); gpio_in[3] = 1'b1;
        repeat (SS - 1) @(negedge clk);
        wb_write(BASE + 32'h14, 32'h8, 4'hF);
        model_write(8'h14, 32'h8, 4'hF);
        model_edges(gpio_in);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_irq got=%b want=1", irq);
        end
        wb_read(BASE + 32'h14, d, a);
        n_checks++;
        if (!a || d !== m_status || d[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_status got=%h want=%h", d, m_status);
        end
        wb_write(BASE + 32'h14, 32'h8, 4'hF);
        model_write(8'h14, 32'h8, 4'hF);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_irq got=%b want=0", irq);
        end
        wb_read(BASE + 32'h14, d, a);
        n_checks++;
        if (!a || d !== m_status) begin
            n_fail++;
            $display("FAIL w1c_status got=%h want=%h", d, m_status);
        end
    endtask

    task automatic test_fall_masked();
        logic [31:0] d;
        logic a;
        @(negedge clk); gpio_in[5] = 1'b0;
        repeat (SS + 3) @(negedge clk);
        model_edges(gpio_in);
        wb_read(BASE + 32'h14, d, a);
        n_checks++;
        if (!a || d !== m_status || d[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL fall_status got=%h want=%h", d, m_status);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_masked_irq got=%b want=0", irq);
        end
        wb_write(BASE + 32'h0C, 32'h20, 4'hF);
        model_write(8'h0C, 32'h20, 4'hF);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL fall_unmask_irq got=%b want=1", irq);
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        logic a;
        wb_read(BASE + 32'h40, d, a);
        n_checks++;
        if (a !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_read ack=%b data=%h want ack=1 data=0", a, d);
        end
        wb_read(BASE + 32'h100, d, a);
        n_checks++;
        if (a !== 1'b0) begin
            n_fail++;
            $display("FAIL out_of_window ack=%b want=0", a);
        end
        wb_write(BASE + 32'h08, 32'h0, 4'hF);
        wb_read(BASE + 32'h08, d, a);
        n_checks++;
        if (!a || d !== m_in) begin
            n_fail++;
            $display("FAIL ro_data_in got=%h want=%h", d, m_in);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, wd, new_in;
        logic [7:0]  ofs;
        logic [3:0]  s;
        logic        a;
        logic [7:0]  ofs_tab [5];
        ofs_tab[0] = 8'h00; ofs_tab[1] = 8'h04; ofs_tab[2] = 8'h0C;
        ofs_tab[3] = 8'h10; ofs_tab[4] = 8'h14;
        for (int i = 0; i < 24; i++) begin
            ofs = ofs_tab[$urandom_range(0, 4)];
            wd  = $urandom;
            s   = 4'($urandom_range(0, 15));
            wb_write(BASE + {24'h0, ofs}, wd, s);
            model_write(ofs, wd, s);
            wb_read(BASE + {24'h0, ofs}, d, a);
            n_checks++;
            if (!a || d !== (ofs == 8'h00 ? m_out : ofs == 8'h04 ? m_oeb : ofs == 8'h0C ? m_en :
                             ofs == 8'h10 ? m_sel : m_status)) begin
                n_fail++;
                $display("FAIL rand_reg ofs=%h got=%h wd=%h sel=%b", ofs, d, wd, s);
            end
            n_checks++;
            if (gpio_out !== m_out || gpio_oeb !== m_oeb || irq !== |(m_status & m_en)) begin
                n_fail++;
                $display("FAIL rand_pads out=%h oeb=%h irq=%b want out=%h oeb=%h irq=%b",
                         gpio_out, gpio_oeb, irq, m_out, m_oeb, |(m_status & m_en));
            end
        end
        for (int i = 0; i < 8; i++) begin
            new_in = $urandom;
            @(negedge clk); gpio_in = new_in;
            repeat (SS + 3) @(negedge clk);
            model_edges(new_in);
            wb_read(BASE + 32'h08, d, a);
            n_checks++;
            if (!a || d !== new_in) begin
                n_fail++;
                $display("FAIL rand_data_in got=%h want=%h", d, new_in);
            end
            wb_read(BASE + 32'h14, d, a);
            n_checks++;
            if (!a || d !== m_status || irq !== |(m_status & m_en)) begin
                n_fail++;
                $display("FAIL rand_status got=%h irq=%b want=%h irq=%b", d, irq, m_status, |(m_status & m_en));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic a;
        logic bad;
        wb_write(BASE + 32'h00, 32'hFFFF_0000, 4'hF);
        wb_write(BASE + 32'h04, 32'h0, 4'hF);
        wb_write(BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; dat_i = 32'h1234_5678; sel = 4'hF;
        rst = 1'b1;
        bad = 1'b0;
        @(negedge clk);
        if (ack !== 1'b0) bad = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        if (ack !== 1'b0) bad = 1'b1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        if (ack !== 1'b0) bad = 1'b1;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_mid_ack ack seen during reset want none");
        end
        n_checks++;
        if (gpio_oeb !== 32'hFFFF_FFFF || gpio_out !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pads oeb=%h out=%h irq=%b want ffffffff/0/0", gpio_oeb, gpio_out, irq);
        end
        repeat (10) @(negedge clk);
        wb_read(BASE + 32'h00, d, a);
        n_checks++;
        if (!a || d !== m_out) begin
            n_fail++;
            $display("FAIL reset_mid_data_out got=%h want=%h", d, m_out);
        end
        wb_read(BASE + 32'h04, d, a);
        n_checks++;
        if (!a || d !== m_oeb) begin
            n_fail++;
            $display("FAIL reset_mid_oeb got=%h want=%h", d, m_oeb);
        end
        wb_read(BASE + 32'h0C, d, a);
        n_checks++;
        if (!a || d !== m_en) begin
            n_fail++;
            $display("FAIL reset_mid_irq_en got=%h want=%h", d, m_en);
        end
        wb_read(BASE + 32'h14, d, a);
        n_checks++;
        if (!a || d !== m_status) begin
            n_fail++;
            $display("FAIL reset_mid_status got=%h want=%h", d, m_status);
        end
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_edge_irq();
        test_w1c_collision();
        test_fall_masked();
        test_decode();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
